// File: rtl/aes_out_pkg.sv
// aes_out_pkg
// Shared constants and the word-select helper for the AES output packer.
//   WORD_W        : width of one streamed output word
//   BLK_W         : width of one AES ciphertext block
//   WORDS_PER_BLK : words streamed per block
//   word_sel()    : picks word <idx> of a block in MSW-first or LSW-first order
package aes_out_pkg;

   localparam int WORD_W        = 32;
   localparam int BLK_W         = 128;
   localparam int WORDS_PER_BLK = BLK_W / WORD_W;
   localparam int IDX_W         = $clog2(WORDS_PER_BLK);

   // slot 0 is blk[WORD_W-1:0]; MSW-first order walks the slots downwards
   function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic             lsw_first);
      logic [IDX_W-1:0] slot;
      slot = lsw_first ? idx : IDX_W'(WORDS_PER_BLK - 1) - idx;
      return blk[slot*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// aes_out_fifo
// Synchronous block FIFO, BLK_W wide and DEPTH entries deep (DEPTH power of two).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, din  : write din at the tail this cycle
//   pop        : drop the head this cycle
//   dout       : current head (valid while !empty)
//   count      : number of stored blocks, 0..DEPTH
//   empty/full : status; full only feeds the overflow assertion upstream
module aes_out_fifo
   import aes_out_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [BLK_W-1:0] din,
   input  logic             pop,
   output logic [BLK_W-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [BLK_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // storage is not reset; the consumer only looks at dout while !empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/aes_out_packer.sv
// aes_out_packer
// Sits behind a fixed-latency pipelined AES-128 core that has no flow control.
// Each issued block is tagged through the core latency, its ciphertext is
// captured into a small FIFO when it emerges, and each buffered block is
// streamed out as WORDS_PER_BLK words over valid/ready. Issue is throttled by
// credits (blocks in the core + blocks buffered) so a capture never overflows.
// Parameters:
//   LATENCY : cycles from issue until the ciphertext is captured (+1 to first word)
//   DEPTH   : FIFO capacity in blocks (power of two, >= 2)
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : issue into the core happens when both are high
//   core_out          : ciphertext bus of the core
//   m_data/m_valid/m_ready/m_last : output word stream, m_last on the final word
//   busy              : a block is in the core or buffered
// Build option:
//   AES_OUT_LSW_FIRST_EN : stream core_out[31:0] first instead of [127:96]
module aes_out_packer
   import aes_out_pkg::*;
#(
   parameter int LATENCY = 21,
   parameter int DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BLK_W-1:0]  core_out,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy
);

   localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef AES_OUT_LSW_FIRST_EN
   localparam logic LSW_FIRST = 1'b1;
`else
   localparam logic LSW_FIRST = 1'b0;
`endif

   logic                issue;
   logic                capture;
   logic                xfer;
   logic                pop;
   logic [LATENCY-2:0]  tag_q;
   logic [CNT_W-1:0]    outstanding;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W:0]      credits_used;
   logic [IDX_W-1:0]    idx;
   logic [BLK_W-1:0]    head;
   logic                fifo_empty;
   logic                fifo_full;

   assign issue = in_valid && in_ready;

   // Tag position 0 is the issue cycle itself, so only positions 1..LATENCY-1
   // need flops. tag_q[k] is high in the cycle k+1 after an issue; the top bit
   // therefore marks the cycle the ciphertext is on core_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_q <= '0;
      else        tag_q <= (tag_q << 1) | (LATENCY-1)'(issue);
   end

   assign capture = tag_q[LATENCY-2];

   // blocks issued but not yet captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({issue, capture})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // a credit is held from issue until the block's last word leaves the FIFO
   assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign in_ready     = credits_used < (CNT_W+1)'(DEPTH);

   aes_out_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .din   (core_out),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // serializer: index only moves on a transfer, so data/last hold under stall
   assign xfer = m_valid && m_ready;
   assign pop  = xfer && (idx == IDX_W'(WORDS_PER_BLK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    idx <= '0;
      else if (xfer) idx <= idx + 1'b1;   // wraps to 0 together with the pop
   end

   assign m_valid = !fifo_empty;
   assign m_last  = m_valid && (idx == IDX_W'(WORDS_PER_BLK - 1));
   // forced to zero when idle so the unreset FIFO storage never shows through
   assign m_data  = m_valid ? word_sel(head, idx, LSW_FIRST) : '0;
   assign busy    = (outstanding != '0) || !fifo_empty;

   // credit accounting must make an overflowing capture impossible
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                    !(capture && fifo_full));

endmodule

// File: tb/tb_aes_out_packer.sv
// tb_aes_out_packer
// Randomized and directed stimulus against a behavioural model: every issued
// block is expected to come out as four words LATENCY cycles later, in order,
// with a credit limit of DEPTH blocks between issue and last-word transfer.
// A core model presents each ciphertext on core_out in cycle t+LATENCY-1 and
// keeps doing so even across a reset.
module tb_aes_out_packer;

   localparam int L = 21;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] core_out;
   logic [31:0]  m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic         busy;
   logic [127:0] cur_ct;

   aes_out_packer #(.LATENCY(L), .DEPTH(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .core_out (core_out),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state
   logic [127:0] ct_hist [int];   // ciphertext by issue cycle (core model)
   logic [31:0]  exp_w [$];
   bit           exp_l [$];
   int           rdy_q [$];       // cycle each outstanding block becomes visible
   int           inflight = 0;
   int           checks = 0;
   int           passes = 0;
   int           n_issue = 0;
   int           n_last = 0;
   bit           prev_stall = 0;
   logic [31:0]  prev_data;
   logic         prev_last;

`ifdef AES_OUT_LSW_FIRST_EN
   localparam bit LSW = 1'b1;
`else
   localparam bit LSW = 1'b0;
`endif

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // monitor / scoreboard / core model, all at the falling edge
   always @(negedge clk) begin
      bit ev;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_last", m_last, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_busy", busy, 0);
         exp_w.delete();
         exp_l.delete();
         rdy_q.delete();
         inflight   = 0;
         prev_stall = 0;
      end else begin
         ev = (rdy_q.size() > 0) && (rdy_q[0] <= cyc);
         chk("m_valid", m_valid, ev);
         chk("in_ready", in_ready, inflight < D);
         chk("busy", busy, inflight != 0);
         if (prev_stall) begin
            chk("hold_data", m_data, prev_data);
            chk("hold_last", m_last, prev_last);
         end
         if (m_valid && ev && exp_w.size() > 0) begin
            chk("m_last", m_last, exp_l[0]);
            if (m_ready) begin
               chk("m_data", m_data, exp_w[0]);
               if (exp_l[0]) begin
                  void'(rdy_q.pop_front());
                  inflight--;
                  n_last++;
               end
               void'(exp_w.pop_front());
               void'(exp_l.pop_front());
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (in_valid && in_ready) begin
            ct_hist[cyc] = cur_ct;
            for (int i = 0; i < 4; i++) begin
               int s;
               s = LSW ? i : 3 - i;
               exp_w.push_back(cur_ct[32*s +: 32]);
               exp_l.push_back(i == 3);
            end
            rdy_q.push_back(cyc + L);
            inflight++;
            n_issue++;
         end
      end
      core_out = ct_hist.exists(cyc - (L - 1)) ? ct_hist[cyc - (L - 1)]
                                                : {$urandom, $urandom, $urandom, $urandom};
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue_one(input logic [127:0] ct);
      cur_ct   = ct;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      m_ready = 1'b1;
      in_valid = 1'b0;
      k = 0;
      while (inflight != 0 && k < 200) begin
         step();
         k++;
      end
      chk(name, inflight, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      m_ready  = 1'b0;
      cur_ct   = '0;
      core_out = '0;
      step(3);
      rst_n = 1'b1;
      step(2);

      // single block, fixed ciphertext
      m_ready = 1'b1;
      n_last  = 0;
      issue_one(128'h00112233_44556677_8899AABB_CCDDEEFF);
      step(30);
      chk("single_last_count", n_last, 1);

      // credit exhaustion: downstream stalled, upstream always valid
      m_ready  = 1'b0;
      n_issue  = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cur_ct = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      in_valid = 1'b0;
      chk("exhaust_issues", n_issue, 4);
      chk("exhaust_busy", busy, 1);
      drain("exhaust_drain");

      // backpressure: 3-block burst with m_ready toggling
      n_last = 0;
      for (int i = 0; i < 3; i++) issue_one({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 60; i++) begin
         m_ready = i[0];
         step();
      end
      chk("bp_last_count", n_last, 3);
      drain("bp_drain");

      // capture lands on the cycle of a 4th-word pop (issue spacing of 4)
      n_last = 0;
      for (int i = 0; i < 3; i++) begin
         issue_one({$urandom, $urandom, $urandom, $urandom});
         step(3);
      end
      step(30);
      chk("simul_last_count", n_last, 3);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cur_ct   = {$urandom, $urandom, $urandom, $urandom};
         in_valid = ($urandom_range(0, 2) != 0);
         m_ready  = ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand_drain");

      // reset with one block buffered and two in the core
      m_ready = 1'b0;
      issue_one({$urandom, $urandom, $urandom, $urandom});
      step(L + 1);
      issue_one({$urandom, $urandom, $urandom, $urandom});
      issue_one({$urandom, $urandom, $urandom, $urandom});
      step(3);
      chk("pre_rst_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_imm_valid", m_valid, 0);
      chk("rst_imm_ready", in_ready, 1);
      chk("rst_imm_busy", busy, 0);
      step();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      n_last  = 0;
      step(40);
      chk("post_rst_no_words", n_last, 0);
      chk("post_rst_busy", busy, 0);

      // traffic still works after reset
      issue_one({$urandom, $urandom, $urandom, $urandom});
      drain("post_rst_drain");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/aes_out_packer.md
# aes_out_packer

Output-side stage placed directly downstream of the pipelined AES-128 core. The core has no valid or stall signals. This block tracks each issued block through the core's fixed latency, captures the 128-bit ciphertext when it emerges, and buffers it in a small FIFO. It then streams each block as four 32-bit words over a valid/ready interface, and throttles issue into the core so that no ciphertext is ever lost.

## Interface
Parameters:
- LATENCY, 21, cycles from issuing a block to the core until its ciphertext is on core_out
- DEPTH, 4, FIFO capacity in 128-bit blocks (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream presents state/key to the core this cycle
- in_ready  out  1  block may be issued; issue = in_valid && in_ready
- core_out  in  128  ciphertext bus of the AES core
- m_data  out  32  output word
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts; word transfer = m_valid && m_ready
- m_last  out  1  high on the 4th word of a block
- busy  out  1  any block in flight or buffered

## Operation
- Tag pipeline: LATENCY-bit shift register; bit 0 loads issue each cycle. When the bit at position LATENCY-1 is high, core_out is written to the FIFO that cycle.
- Credit: counter `outstanding` (0..DEPTH). It increments on issue and decrements on capture; if both happen in the same cycle it is unchanged.
- in_ready = (outstanding + fifo_count) < DEPTH, registered-free (combinational from state). This guarantees a capture never finds the FIFO full.
- Serializer: 2-bit word index. Word 0 = core_out[127:96], word 3 = [31:0] (default order).
  - Index advances on each transfer. On the transfer with index 3, the FIFO head is popped and the index wraps to 0.
- m_valid = FIFO not empty; m_last = m_valid && index==3.
- m_data and m_last hold stable while m_valid && !m_ready.
- busy = (outstanding != 0) || FIFO not empty.
- Simultaneous capture and pop: both happen, and fifo_count is unchanged.
- A capture into an empty FIFO with no pop makes m_valid high the next cycle.
- Reset (asynchronous, any time) clears the tags, outstanding, FIFO pointers/count and index. Blocks in flight inside the core are discarded, and their tags are gone.
- Reset values: in_ready=1, m_valid=0, m_last=0, m_data=0, busy=0.

## Timing
- Issue at cycle t → capture at the edge ending cycle t+LATENCY−1 → m_valid first high in cycle t+LATENCY.
  - Minimum issue-to-first-word latency is LATENCY cycles.
- With m_ready held high: 4 words in 4 consecutive cycles per block. Back-to-back blocks stream with no bubble.
- Sustained throughput is one block per 4 cycles, so in_ready duty falls to 1/4 once credits are exhausted.
- in_ready drops in the same cycle the last credit is consumed. It reasserts the cycle after the pop of the 4th word frees a credit.

## Configuration
- AES_OUT_LSW_FIRST_EN defined: word 0 = core_out[31:0], word 3 = [127:96].
- Not defined: MSW first as above.
- Nothing else changes.

## Structure
- Package aes_out_pkg holds:
  - WORD_W=32, BLK_W=128, WORDS_PER_BLK=4
  - the word-select function
- Sub-module aes_out_fifo: synchronous FIFO of BLK_W×DEPTH with push, pop, count, empty and full.
  - Same clock and reset; full is for assertion only.

## Test plan
- Single block: issue at t with core_out model = 128'h00112233_44556677_8899AABB_CCDDEEFF delayed LATENCY, m_ready=1.
  - Words 00112233, 44556677, 8899AABB, CCDDEEFF in cycles t+21..t+24; m_last only on the last.
  - The same stimulus with AES_OUT_LSW_FIRST_EN gives the reverse word order.
- Credit exhaustion: m_ready=0, in_valid=1 continuously.
  - Exactly 4 issues, then in_ready=0.
  - After 21 more cycles fifo_count=4, outstanding=0; no capture is lost.
- Backpressure: toggle m_ready every cycle during a 3-block burst.
  - m_data stable while stalled; 12 words in order; 3 m_last pulses.
- Simultaneous capture+pop: arrange a capture in the same cycle as a 4th-word transfer.
  - fifo_count unchanged and streaming continues seamlessly.
- Reset mid-flight: assert rst_n=0 for one cycle with 2 blocks in the core and 1 buffered.
  - Outputs go to reset values immediately.
  - No stale words appear afterwards, even when the core_out model later presents the old ciphertexts.
  - busy=0.
